// File: rtl/sbox_scheduler.sv
// ASCON substitution layer: NUM_SBOX 5-bit sboxes time-shared over the 64 state columns.
// Define SBOX_SCHEDULER_ABORT_EN to add the i_abort port.
module sbox_scheduler_sbox (
    input  logic [4:0] i_x,
    output logic [4:0] o_y
);
    // i_x[4] is x0 ... i_x[0] is x4; bitsliced ASCON sbox
    logic w_a0, w_a1, w_a2, w_a3, w_a4;
    logic w_b0, w_b1, w_b2, w_b3, w_b4;

    assign w_a0 = i_x[4] ^ i_x[0];
    assign w_a1 = i_x[3];
    assign w_a2 = i_x[2] ^ i_x[3];
    assign w_a3 = i_x[1];
    assign w_a4 = i_x[0] ^ i_x[1];

    assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
    assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
    assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
    assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
    assign w_b4 = w_a4 ^ (~w_a0 & w_a1);

    assign o_y[4] = w_b0 ^ w_b4;
    assign o_y[3] = w_b1 ^ w_b0;
    assign o_y[2] = ~w_b2;
    assign o_y[1] = w_b3 ^ w_b2;
    assign o_y[0] = w_b4;
endmodule

module sbox_scheduler #(
    parameter int NUM_SBOX = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [4:0][63:0] i_state,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [4:0][63:0] o_state,
`ifdef SBOX_SCHEDULER_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_busy
);
    localparam int STEPS = 64 / NUM_SBOX;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_fsm;
    logic [CW-1:0]    r_cnt;
    logic [4:0][63:0] r_state;
    logic [4:0][63:0] w_next;
    logic [4:0]       w_sin  [NUM_SBOX];
    logic [4:0]       w_sout [NUM_SBOX];
    logic             w_last;
    logic             w_abort;

`ifdef SBOX_SCHEDULER_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [5:0] col(input logic [CW-1:0] c, input int g);
        return 6'(int'(c) * NUM_SBOX + g);
    endfunction

    assign w_last = (r_cnt == CW'(STEPS - 1));

    always_comb begin
        for (int g = 0; g < NUM_SBOX; g++) begin
            w_sin[g] = {r_state[0][col(r_cnt, g)], r_state[1][col(r_cnt, g)],
                        r_state[2][col(r_cnt, g)], r_state[3][col(r_cnt, g)],
                        r_state[4][col(r_cnt, g)]};
        end
    end

    // substituted columns go back to the bit positions they came from
    always_comb begin
        w_next = r_state;
        for (int g = 0; g < NUM_SBOX; g++) begin
            for (int k = 0; k < 5; k++) begin
                w_next[k][col(r_cnt, g)] = w_sout[g][4-k];
            end
        end
    end

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
        sbox_scheduler_sbox u_sbox (
            .i_x (w_sin[g]),
            .o_y (w_sout[g])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_fsm   <= IDLE;
            r_cnt   <= '0;
            r_state <= '0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (i_valid) begin
                        r_state <= i_state;
                        r_cnt   <= '0;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_cnt <= '0;
                        r_fsm <= IDLE;
                    end else begin
                        r_state <= w_next;
                        if (w_last) begin
                            r_cnt <= '0;
                            r_fsm <= DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (w_abort || i_ready) begin
                        r_cnt <= '0;
                        r_fsm <= IDLE;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = reset_n && (r_fsm == IDLE);
    assign o_valid = (r_fsm == DONE);
    assign o_busy  = (r_fsm == RUN);
    assign o_state = r_state;
endmodule

// File: doc/sbox_scheduler.md
SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 Parameter: NUM_SBOX, default 4, number of sbox instances applied per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 Port: clock  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port: i_valid  input  1  input state is present.
REQ-005 Port: o_ready  output  1  block can accept a new state.
REQ-006 Port: i_state  input  5x64  ASCON state words x0..x4.
REQ-007 Port: o_valid  output  1  substituted state is present on o_state.
REQ-008 Port: i_ready  input  1  downstream accepts o_state.
REQ-009 Port: o_state  output  5x64  substituted state words x0..x4.
REQ-010 Port: o_busy  output  1  high while in RUN.

Function
REQ-011 The block SHALL instantiate exactly NUM_SBOX sbox instances and SHALL time-share them across the 64 state columns.
REQ-012 Column j SHALL be mapped to sbox input {x0[j],x1[j],x2[j],x3[j],x4[j]} (x0 in the MSB), and the sbox output SHALL be written back to the same bit positions.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 In IDLE: o_ready=1; on i_valid=1, i_state SHALL be captured into the internal state register, the column counter SHALL be cleared to 0, and the FSM SHALL go to RUN.
REQ-015 In RUN: each cycle SHALL substitute columns counter*NUM_SBOX .. counter*NUM_SBOX+NUM_SBOX-1 in place and then increment the counter.
REQ-016 RUN SHALL last exactly STEPS=64/NUM_SBOX cycles; when the counter equals STEPS-1, the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-017 In DONE: o_valid=1 and o_state SHALL equal the state register; when i_ready=1, the FSM SHALL return to IDLE.
REQ-018 o_valid SHALL first assert STEPS+1 cycles after the accepting edge (NUM_SBOX=4: 17 cycles).
REQ-019 o_ready SHALL be 0 in RUN and DONE; i_valid in those states SHALL be ignored, with no capture.
REQ-020 o_state and o_valid SHALL stay stable in DONE while i_ready=0.
REQ-021 o_busy SHALL be high exactly while the FSM is in RUN.
REQ-022 The counter width SHALL be max(1, log2(STEPS)) bits; for NUM_SBOX=64, RUN SHALL last one cycle.

Reset
REQ-023 With reset_n=0 at a clock edge: FSM->IDLE, counter->0, state register->0, o_valid=0, o_busy=0, o_ready=0 during reset and 1 after release.
REQ-024 Reset asserted in RUN or DONE SHALL abandon the operation with no o_valid pulse, and the next operation SHALL behave as from power-up.

Configuration
REQ-025 Macro SBOX_SCHEDULER_ABORT_EN SHALL, when defined, add port i_abort (input, 1 bit); i_abort=1 in RUN or DONE SHALL return the FSM to IDLE on the next edge and clear the counter and o_valid; i_abort has priority over i_ready and is ignored in IDLE.
REQ-026 Without SBOX_SCHEDULER_ABORT_EN, port i_abort SHALL NOT exist and the behaviour SHALL be as in REQ-013..REQ-022.

Verification
REQ-027 NUM_SBOX=4, i_state all zeros, i_ready=1 -> o_valid 17 cycles after accept; x2=0xFFFFFFFFFFFFFFFF, x0=x1=x3=x4=0.
REQ-028 i_state all ones -> x1=0, x0=x2=x3=x4=0xFFFFFFFFFFFFFFFF, for each NUM_SBOX in {1,4,64}, with latencies 65, 17 and 2 cycles respectively.
REQ-029 Random states, 1000 vectors, with i_ready held low for a random 0-5 cycles -> o_state matches the golden per-column S_TABLE model; o_state is stable while stalled, and exactly one accept per result.
REQ-030 i_valid held high through RUN/DONE -> no recapture; the second state is accepted only after returning to IDLE.
REQ-031 reset_n=0 at counter=7 -> o_valid=0, o_ready=1 after release; the next vector produces a correct result with nominal latency.
REQ-032 With SBOX_SCHEDULER_ABORT_EN: i_abort=1 at counter=3 -> IDLE next cycle, no o_valid; i_abort and i_ready both high in DONE -> IDLE, counter 0.
